// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, memory handshake and datapath control strobes
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] mem_size;
    logic [1:0] pc_source;
    logic [3:0] state;

    modport master (
        input  opcode, funct, rt, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, link, alu_src_a, alu_src_b,
               alu_op, mem_size, pc_source, state
    );

    modport slave (
        output opcode, funct, rt, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, link, alu_src_a, alu_src_b,
               alu_op, mem_size, pc_source, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS-style control FSM with Moore-decoded datapath strobes
module multicycle_controller (
    input logic                       clk,
    input logic                       rst_n,
    multicycle_controller_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    state_t     state;
    state_t     dec_next;
    logic       is_load, is_store, is_imm, is_br, is_rtype, is_jr, is_jal, br_ok;
    logic [1:0] mem_sz;
    logic [3:0] r_op, i_op, b_op;

    assign is_rtype = bus.opcode == 6'b000000;
    assign is_load  = bus.opcode inside {6'b100011, 6'b100001, 6'b100000};
    assign is_store = bus.opcode inside {6'b101011, 6'b101001, 6'b101000};
    assign is_imm   = bus.opcode inside {6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001110};
    assign is_br    = bus.opcode inside {6'b000100, 6'b000101, 6'b000111, 6'b000110, 6'b000001};
    assign is_jr    = is_rtype && bus.funct == 6'b001000;
    assign is_jal   = bus.opcode == 6'b000011;
    // Low opcode bits distinguish word (11), half (01) and byte (00) accesses
    assign mem_sz   = bus.opcode[1:0] == 2'b11 ? 2'b00 : bus.opcode[0] ? 2'b01 : 2'b10;
    assign bus.state = state;

    // Decode-state successor and per-class ALU operation selection
    always_comb begin
        dec_next = (is_load || is_store) ? MEMADR :
                   is_jr ? JUMP :
                   (is_rtype && bus.funct == 6'b000000) ? FETCH :
                   is_rtype ? EXEC :
                   is_imm ? IEXEC :
                   is_br ? BRANCH :
                   (bus.opcode == 6'b000010 || is_jal) ? JUMP : FETCH;
        case (bus.funct)
            6'b100000: r_op = 4'b0010;
            6'b100010: r_op = 4'b0011;
            6'b011000: r_op = 4'b1001;
            6'b100100: r_op = 4'b0000;
            6'b100101: r_op = 4'b0001;
            6'b100111: r_op = 4'b0101;
            6'b100110: r_op = 4'b0110;
            6'b000010: r_op = 4'b1000;
            6'b101010: r_op = 4'b0100;
            default:   r_op = 4'b0010;
        endcase
        case (bus.opcode)
            6'b001100: i_op = 4'b0000;
            6'b001101: i_op = 4'b0001;
            6'b001010: i_op = 4'b0100;
            6'b001110: i_op = 4'b0110;
            default:   i_op = 4'b0010;
        endcase
        br_ok = 1'b1;
        case (bus.opcode)
            6'b000100: b_op = 4'b1011;
            6'b000101: b_op = 4'b1100;
            6'b000111: b_op = 4'b1101;
            6'b000110: b_op = 4'b1110;
            default: begin
                b_op  = bus.rt == 5'b00001 ? 4'b1010 : bus.rt == 5'b00000 ? 4'b1111 : 4'b0010;
                br_ok = bus.rt inside {5'b00000, 5'b00001};
            end
        endcase
    end

    // State register; reset aborts any access and returns to FETCH at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= bus.mem_ready ? DECODE : FETCH;
                DECODE:  state <= dec_next;
                MEMADR:  state <= is_store ? MEMWR : MEMRD;
                MEMRD:   state <= bus.mem_ready ? MEMWB : MEMRD;
                MEMWR:   state <= bus.mem_ready ? FETCH : MEMWR;
                EXEC:    state <= ALUWB;
                IEXEC:   state <= IWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Moore output decode; only FETCH's IR/PC writes depend on the memory handshake
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.link          = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 4'b0010;
        bus.mem_size      = 2'b00;
        bus.pc_source     = 2'b00;
        case (state)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: bus.alu_src_b = 2'b11;
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.mem_size  = mem_sz;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                bus.mem_size = mem_sz;
            end
            MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                bus.mem_size  = mem_sz;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.mem_size   = mem_sz;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = r_op;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = i_op;
            end
            IWB: bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.pc_write_cond = br_ok;
                bus.pc_source     = 2'b01;
                bus.alu_op        = b_op;
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = is_jr ? 2'b11 : 2'b10;
                bus.reg_write = is_jal;
                bus.link      = is_jal;
            end
            default: ;
        endcase
    end
endmodule
